pipeline_hazard_ctrl: RTL and testbench

//  Central pipeline controller for the fetch/decode/execute/memory core. Detects load-use
//  and multi-cycle ALU hazards, sequences branch/jump and external flushes, and drives
//  per-stage stall/flush/bubble controls plus rs1/rs2 forwarding selects. It also keeps

---
 rtl/pipeline_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: load-use and multi-cycle ALU stalls, branch/external flush
// sequencing, rs1/rs2 forwarding selects and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int AWIDTH      = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 hz_clk,
    input  logic                 hz_rst,
    input  logic                 hz_i_ce,
    input  logic                 hz_i_ext_stall,
    input  logic                 hz_i_ext_flush,
    input  logic                 hz_i_id_valid,
    input  logic [AWIDTH-1:0]    hz_i_id_rs1,
    input  logic [AWIDTH-1:0]    hz_i_id_rs2,
    input  logic [AWIDTH-1:0]    hz_i_ex_rd,
    input  logic                 hz_i_ex_we,
    input  logic                 hz_i_ex_load,
    input  logic [AWIDTH-1:0]    hz_i_mem_rd,
    input  logic                 hz_i_mem_we,
    input  logic [AWIDTH-1:0]    hz_i_wb_rd,
    input  logic                 hz_i_wb_we,
    input  logic                 hz_i_change_pc,
    input  logic                 hz_i_alu_busy,
    output logic                 hz_o_stall_if,
    output logic                 hz_o_stall_id,
    output logic                 hz_o_stall_ex,
    output logic                 hz_o_bubble_ex,
    output logic                 hz_o_flush_id,
    output logic                 hz_o_flush_ex,
    output logic [1:0]           hz_o_fwd_rs1,
    output logic [1:0]           hz_o_fwd_rs2,
    output logic [1:0]           hz_o_state,
    output logic [CNT_WIDTH-1:0] hz_o_stall_cnt,
    output logic [CNT_WIDTH-1:0] hz_o_flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_FLUSH    = 2'b01;
    localparam logic [1:0] ST_ALU_WAIT = 2'b10;

    localparam int RW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [RW-1:0]        REM_LOAD = RW'(FLUSH_DEPTH - 1);
    localparam logic [RW-1:0]        REM_ONE  = RW'(1);
    localparam logic [1:0]           ST_AFTER_FLUSH = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [AWIDTH-1:0]    REG_X0   = {AWIDTH{1'b0}};

    logic [1:0]           r_state;
    logic [RW-1:0]        r_remaining;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic [1:0]    w_state_nxt;
    logic [RW-1:0] w_remaining_nxt;
    logic          w_stall_if;
    logic          w_stall_id;
    logic          w_stall_ex;
    logic          w_bubble_ex;
    logic          w_flush_id;
    logic          w_flush_ex;
    logic          w_flush_event;
    logic          w_load_use;
    logic [1:0]    w_fwd_rs1;
    logic [1:0]    w_fwd_rs2;

    // MEM result is younger than WB, so it takes precedence; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [AWIDTH-1:0] src,
        input logic [AWIDTH-1:0] mem_rd,
        input logic              mem_we,
        input logic [AWIDTH-1:0] wb_rd,
        input logic              wb_we
    );
        if ((src != REG_X0) && mem_we && (mem_rd == src)) begin
            return 2'b01;
        end else if ((src != REG_X0) && wb_we && (wb_rd == src)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    assign w_load_use = hz_i_id_valid & hz_i_ex_load & hz_i_ex_we & (hz_i_ex_rd != REG_X0) &
                        ((hz_i_ex_rd == hz_i_id_rs1) | (hz_i_ex_rd == hz_i_id_rs2));
    assign w_fwd_rs1  = fwd_sel(hz_i_id_rs1, hz_i_mem_rd, hz_i_mem_we, hz_i_wb_rd, hz_i_wb_we);
    assign w_fwd_rs2  = fwd_sel(hz_i_id_rs2, hz_i_mem_rd, hz_i_mem_we, hz_i_wb_rd, hz_i_wb_we);

    // Prioritised per-cycle control decision and next-state selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_stall_if      = 1'b0;
        w_stall_id      = 1'b0;
        w_stall_ex      = 1'b0;
        w_bubble_ex     = 1'b0;
        w_flush_id      = 1'b0;
        w_flush_ex      = 1'b0;
        w_flush_event   = 1'b0;
        if (!hz_i_ce) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_stall_ex = 1'b1;
        end else if (hz_i_ext_flush) begin
            w_flush_id      = 1'b1;
            w_flush_ex      = 1'b1;
            w_flush_event   = 1'b1;
            w_state_nxt     = ST_AFTER_FLUSH;
            w_remaining_nxt = REM_LOAD;
        end else if (hz_i_alu_busy) begin
            w_stall_if      = 1'b1;
            w_stall_id      = 1'b1;
            w_stall_ex      = 1'b1;
            w_state_nxt     = ST_ALU_WAIT;
            w_remaining_nxt = {RW{1'b0}};
        end else if (hz_i_change_pc) begin
            w_flush_id      = 1'b1;
            w_flush_ex      = 1'b1;
            w_flush_event   = 1'b1;
            w_state_nxt     = ST_AFTER_FLUSH;
            w_remaining_nxt = REM_LOAD;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    // ID is being squashed, so a load-use match there is meaningless.
                    w_flush_id = 1'b1;
                    if (hz_i_ext_stall) begin
                        w_stall_if = 1'b1;
                        w_stall_id = 1'b1;
                        w_stall_ex = 1'b1;
                    end else begin
                        w_stall_if = 1'b0;
                    end
                    if (r_remaining <= REM_ONE) begin
                        w_state_nxt     = ST_RUN;
                        w_remaining_nxt = {RW{1'b0}};
                    end else begin
                        w_state_nxt     = ST_FLUSH;
                        w_remaining_nxt = r_remaining - REM_ONE;
                    end
                end
                ST_RUN, ST_ALU_WAIT: begin
                    w_state_nxt = ST_RUN;
                    if (w_load_use) begin
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_bubble_ex = 1'b1;
                    end else if (hz_i_ext_stall) begin
                        w_stall_if = 1'b1;
                        w_stall_id = 1'b1;
                        w_stall_ex = 1'b1;
                    end else begin
                        w_stall_if = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt     = ST_RUN;
                    w_remaining_nxt = {RW{1'b0}};
                end
            endcase
        end
    end

    // State, flush countdown and saturating event counters; all frozen while ce=0.
    always_ff @(posedge hz_clk or posedge hz_rst) begin
        if (hz_rst) begin
            r_state     <= ST_RUN;
            r_remaining <= {RW{1'b0}};
            r_stall_cnt <= {CNT_WIDTH{1'b0}};
            r_flush_cnt <= {CNT_WIDTH{1'b0}};
        end else if (hz_i_ce) begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            if (w_stall_if && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_event && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign hz_o_stall_if  = w_stall_if  & ~hz_rst;
    assign hz_o_stall_id  = w_stall_id  & ~hz_rst;
    assign hz_o_stall_ex  = w_stall_ex  & ~hz_rst;
    assign hz_o_bubble_ex = w_bubble_ex & ~hz_rst;
    assign hz_o_flush_id  = w_flush_id  & ~hz_rst;
    assign hz_o_flush_ex  = w_flush_ex  & ~hz_rst;
    assign hz_o_fwd_rs1   = hz_rst ? 2'b00 : w_fwd_rs1;
    assign hz_o_fwd_rs2   = hz_rst ? 2'b00 : w_fwd_rs2;
    assign hz_o_state     = r_state;
    assign hz_o_stall_cnt = r_stall_cnt;
    assign hz_o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_DEPTH=2, CNT_WIDTH=4).
module tb_pipeline_hazard_ctrl;

    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] FLS = 2'b01;
    localparam logic [1:0] AW  = 2'b10;
    // Control vector order: {stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b111000;
    localparam logic [5:0] C_LU    = 6'b110100;
    localparam logic [5:0] C_FEV   = 6'b000011;
    localparam logic [5:0] C_FID   = 6'b000010;

    logic hz_clk = 1'b0;
    logic hz_rst, hz_i_ce, hz_i_ext_stall, hz_i_ext_flush, hz_i_id_valid;
    logic [4:0] hz_i_id_rs1, hz_i_id_rs2, hz_i_ex_rd, hz_i_mem_rd, hz_i_wb_rd;
    logic hz_i_ex_we, hz_i_ex_load, hz_i_mem_we, hz_i_wb_we, hz_i_change_pc, hz_i_alu_busy;
    logic hz_o_stall_if, hz_o_stall_id, hz_o_stall_ex, hz_o_bubble_ex, hz_o_flush_id, hz_o_flush_ex;
    logic [1:0] hz_o_fwd_rs1, hz_o_fwd_rs2, hz_o_state;
    logic [3:0] hz_o_stall_cnt, hz_o_flush_cnt;
    logic [5:0] ctrl;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_stall = 4'd0;
    logic [3:0] exp_flush = 4'd0;

    pipeline_hazard_ctrl #(.AWIDTH(5), .FLUSH_DEPTH(2), .CNT_WIDTH(4)) dut (
        .hz_clk(hz_clk), .hz_rst(hz_rst), .hz_i_ce(hz_i_ce),
        .hz_i_ext_stall(hz_i_ext_stall), .hz_i_ext_flush(hz_i_ext_flush),
        .hz_i_id_valid(hz_i_id_valid), .hz_i_id_rs1(hz_i_id_rs1), .hz_i_id_rs2(hz_i_id_rs2),
        .hz_i_ex_rd(hz_i_ex_rd), .hz_i_ex_we(hz_i_ex_we), .hz_i_ex_load(hz_i_ex_load),
        .hz_i_mem_rd(hz_i_mem_rd), .hz_i_mem_we(hz_i_mem_we),
        .hz_i_wb_rd(hz_i_wb_rd), .hz_i_wb_we(hz_i_wb_we),
        .hz_i_change_pc(hz_i_change_pc), .hz_i_alu_busy(hz_i_alu_busy),
        .hz_o_stall_if(hz_o_stall_if), .hz_o_stall_id(hz_o_stall_id), .hz_o_stall_ex(hz_o_stall_ex),
        .hz_o_bubble_ex(hz_o_bubble_ex), .hz_o_flush_id(hz_o_flush_id), .hz_o_flush_ex(hz_o_flush_ex),
        .hz_o_fwd_rs1(hz_o_fwd_rs1), .hz_o_fwd_rs2(hz_o_fwd_rs2), .hz_o_state(hz_o_state),
        .hz_o_stall_cnt(hz_o_stall_cnt), .hz_o_flush_cnt(hz_o_flush_cnt)
    );

    always #5 hz_clk = ~hz_clk;

    assign ctrl = {hz_o_stall_if, hz_o_stall_id, hz_o_stall_ex, hz_o_bubble_ex, hz_o_flush_id, hz_o_flush_ex};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        hz_i_ce = 1'b1; hz_i_ext_stall = 1'b0; hz_i_ext_flush = 1'b0; hz_i_id_valid = 1'b0;
        hz_i_id_rs1 = 5'd0; hz_i_id_rs2 = 5'd0; hz_i_ex_rd = 5'd0; hz_i_ex_we = 1'b0;
        hz_i_ex_load = 1'b0; hz_i_mem_rd = 5'd0; hz_i_mem_we = 1'b0; hz_i_wb_rd = 5'd0;
        hz_i_wb_we = 1'b0; hz_i_change_pc = 1'b0; hz_i_alu_busy = 1'b0;
    endtask

    task automatic load_use_inputs();
        hz_i_id_valid = 1'b1; hz_i_ex_load = 1'b1; hz_i_ex_we = 1'b1;
        hz_i_ex_rd = 5'd5; hz_i_id_rs2 = 5'd5; hz_i_id_rs1 = 5'd3;
    endtask

    // Check combinational outputs mid-cycle, clock once, then check the counters.
    task automatic cyc(input string tag, input logic [5:0] ec, input logic [1:0] es,
                       input logic [1:0] ef1, input logic [1:0] ef2);
        @(negedge hz_clk);
        chk({tag, "_ctrl"}, {26'd0, ctrl}, {26'd0, ec});
        chk({tag, "_state"}, {30'd0, hz_o_state}, {30'd0, es});
        chk({tag, "_fwd"}, {28'd0, hz_o_fwd_rs1, hz_o_fwd_rs2}, {28'd0, ef1, ef2});
        @(posedge hz_clk);
        #1;
        if (hz_i_ce) begin
            if (ec[5] && (exp_stall != 4'hF)) exp_stall = exp_stall + 4'd1;
            if (ec[0] && (exp_flush != 4'hF)) exp_flush = exp_flush + 4'd1;
        end
        chk({tag, "_stall_cnt"}, {28'd0, hz_o_stall_cnt}, {28'd0, exp_stall});
        chk({tag, "_flush_cnt"}, {28'd0, hz_o_flush_cnt}, {28'd0, exp_flush});
    endtask

    initial begin
        idle();
        hz_rst = 1'b1;
        hz_i_ce = 1'b0; hz_i_ext_stall = 1'b1; hz_i_change_pc = 1'b1;
        hz_i_id_rs1 = 5'd7; hz_i_mem_rd = 5'd7; hz_i_mem_we = 1'b1;
        #3;
        chk("rst_ctrl", {26'd0, ctrl}, 32'd0);
        chk("rst_fwd", {28'd0, hz_o_fwd_rs1, hz_o_fwd_rs2}, 32'd0);
        chk("rst_state", {30'd0, hz_o_state}, 32'd0);
        chk("rst_cnts", {24'd0, hz_o_stall_cnt, hz_o_flush_cnt}, 32'd0);
        idle();
        @(posedge hz_clk); #1;
        hz_rst = 1'b0;

        // Load-use: one-cycle stall + bubble, then MEM forwarding resolves it.
        load_use_inputs();
        cyc("lu_stall", C_LU, RUN, 2'b00, 2'b00);
        hz_i_ex_load = 1'b0; hz_i_ex_we = 1'b0; hz_i_mem_rd = 5'd5; hz_i_mem_we = 1'b1;
        cyc("lu_fwd", C_NONE, RUN, 2'b00, 2'b01);

        // Forwarding priority and x0.
        idle();
        hz_i_mem_rd = 5'd7; hz_i_mem_we = 1'b1; hz_i_wb_rd = 5'd7; hz_i_wb_we = 1'b1; hz_i_id_rs1 = 5'd7;
        cyc("fwd_mem_wins", C_NONE, RUN, 2'b01, 2'b00);
        hz_i_mem_we = 1'b0; hz_i_id_rs2 = 5'd7;
        cyc("fwd_wb", C_NONE, RUN, 2'b10, 2'b10);
        idle();
        hz_i_mem_rd = 5'd0; hz_i_mem_we = 1'b1; hz_i_wb_we = 1'b1;
        cyc("fwd_x0", C_NONE, RUN, 2'b00, 2'b00);

        // Branch flush, depth 2.
        idle(); hz_i_change_pc = 1'b1;
        cyc("br_ev", C_FEV, RUN, 2'b00, 2'b00);
        idle();
        cyc("br_fls", C_FID, FLS, 2'b00, 2'b00);
        cyc("br_done", C_NONE, RUN, 2'b00, 2'b00);

        // Multi-cycle ALU masks change_pc, then branch taken on exit.
        hz_i_alu_busy = 1'b1; hz_i_change_pc = 1'b1;
        cyc("alu_0", C_STALL, RUN, 2'b00, 2'b00);
        cyc("alu_1", C_STALL, AW, 2'b00, 2'b00);
        cyc("alu_2", C_STALL, AW, 2'b00, 2'b00);
        cyc("alu_3", C_STALL, AW, 2'b00, 2'b00);
        hz_i_alu_busy = 1'b0;
        cyc("alu_exit_br", C_FEV, AW, 2'b00, 2'b00);
        idle();
        cyc("alu_br_fls", C_FID, FLS, 2'b00, 2'b00);
        cyc("alu_br_done", C_NONE, RUN, 2'b00, 2'b00);

        // Branch beats load-use; ce=0 freezes FLUSH; load-use ignored in FLUSH.
        load_use_inputs(); hz_i_change_pc = 1'b1;
        cyc("br_lu", C_FEV, RUN, 2'b00, 2'b00);
        idle(); hz_i_ce = 1'b0;
        cyc("ce0_a", C_STALL, FLS, 2'b00, 2'b00);
        cyc("ce0_b", C_STALL, FLS, 2'b00, 2'b00);
        idle(); load_use_inputs();
        cyc("ce_resume", C_FID, FLS, 2'b00, 2'b00);
        idle();
        cyc("ce_done", C_NONE, RUN, 2'b00, 2'b00);

        // ext_flush beats alu_busy; busy from FLUSH abandons the flush.
        hz_i_ext_flush = 1'b1; hz_i_alu_busy = 1'b1;
        cyc("xf_busy", C_FEV, RUN, 2'b00, 2'b00);
        hz_i_ext_flush = 1'b0;
        cyc("busy_in_fls", C_STALL, FLS, 2'b00, 2'b00);
        idle();
        cyc("busy_exit", C_NONE, AW, 2'b00, 2'b00);
        cyc("busy_run", C_NONE, RUN, 2'b00, 2'b00);

        // Stall counter saturation.
        hz_i_ext_stall = 1'b1;
        for (int i = 0; (i < 20) && (exp_stall < 4'hE); i++) begin
            cyc("xs_fill", C_STALL, RUN, 2'b00, 2'b00);
        end
        chk("stall_cnt_near_max", {28'd0, hz_o_stall_cnt}, 32'd14);
        for (int i = 0; i < 3; i++) begin
            cyc("xs_sat", C_STALL, RUN, 2'b00, 2'b00);
        end
        chk("stall_cnt_sat", {28'd0, hz_o_stall_cnt}, 32'd15);

        // Asynchronous reset mid-FLUSH.
        idle(); hz_i_change_pc = 1'b1;
        cyc("pre_rst_ev", C_FEV, RUN, 2'b00, 2'b00);
        idle(); hz_i_id_rs1 = 5'd7; hz_i_mem_rd = 5'd7; hz_i_mem_we = 1'b1;
        #2;
        chk("pre_rst_fls", {29'd0, hz_o_flush_id, hz_o_state}, {29'd0, 1'b1, FLS});
        hz_rst = 1'b1;
        #1;
        chk("arst_ctrl", {26'd0, ctrl}, 32'd0);
        chk("arst_fwd", {28'd0, hz_o_fwd_rs1, hz_o_fwd_rs2}, 32'd0);
        chk("arst_state", {30'd0, hz_o_state}, 32'd0);
        chk("arst_cnts", {24'd0, hz_o_stall_cnt, hz_o_flush_cnt}, 32'd0);
        exp_stall = 4'd0; exp_flush = 4'd0;
        @(posedge hz_clk); #1;
        hz_rst = 1'b0;
        cyc("post_rst", C_NONE, RUN, 2'b01, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
